// File: rtl/cruise_ctrl.sv
// Cruise-control sequencer: arbitrates the Vehicle_Logic accelerator input between
// the driver pedal and a proportional speed-hold command, stepping on tick_speed.
module cruise_ctrl #(
    parameter logic [7:0]  SPD_MIN    = 8'd30,
    parameter logic [7:0]  SPD_MAX    = 8'd180,
    parameter logic [7:0]  SPD_STEP   = 8'd5,
    parameter logic [7:0]  ACCEL_BASE = 8'd60,
    parameter int unsigned KP_SHIFT   = 2,
    parameter logic [7:0]  OVR_THRESH = 8'd10
) (
    input  logic       CLK,
    input  logic       global_safe_rst,
    input  logic       tick_speed,
    input  logic       engine_on,
    input  logic       sw_enable,
    input  logic       gear_is_d,
    input  logic [7:0] speed,
    input  logic [7:0] adc_accel,
    input  logic       brake,
    input  logic       key_set,
    input  logic       key_res,
    input  logic       key_cancel,
    output logic [7:0] accel_out,
    output logic [7:0] target_speed,
    output logic       cruise_active,
    output logic [1:0] cc_state
);

    typedef enum logic [1:0] {
        CC_OFF      = 2'd0,
        CC_STANDBY  = 2'd1,
        CC_ACTIVE   = 2'd2,
        CC_OVERRIDE = 2'd3
    } cc_state_t;

    cc_state_t  state_r;
    cc_state_t  state_nx_s;
    logic [7:0] target_r;
    logic [7:0] target_nx_s;
    logic [7:0] cmd_r;
    logic [7:0] accel_out_r;
    logic       cruise_active_r;
    logic       prev_set_r;
    logic       prev_res_r;
    logic       prev_cancel_r;

    logic       set_edge_s;
    logic       res_edge_s;
    logic       cancel_edge_s;
    logic       engage_ok_s;
    logic       engaged_s;
    logic       engaged_nx_s;
    logic [8:0] tgt_sum_s;
    logic [8:0] tgt_diff_s;
    logic [7:0] tgt_up_s;
    logic [7:0] tgt_dn_s;

    // Proportional command: ACCEL_BASE + (target - speed) * 2^KP_SHIFT, clamped to 0..255.
    function automatic logic [7:0] calc_cmd(input logic [7:0] tgt, input logic [7:0] spd);
        logic signed [8:0]  err;
        logic signed [11:0] val;
        err = $signed({1'b0, tgt}) - $signed({1'b0, spd});
        val = $signed({4'b0000, ACCEL_BASE}) + ($signed({{3{err[8]}}, err}) <<< KP_SHIFT);
        if (val < 12'sd0) begin
            calc_cmd = 8'd0;
        end else if (val > 12'sd255) begin
            calc_cmd = 8'd255;
        end else begin
            calc_cmd = val[7:0];
        end
    endfunction

    assign set_edge_s    = key_set & ~prev_set_r;
    assign res_edge_s    = key_res & ~prev_res_r;
    assign cancel_edge_s = key_cancel & ~prev_cancel_r;
    assign engage_ok_s   = engine_on & gear_is_d & ~brake &
                           (speed >= SPD_MIN) & (speed <= SPD_MAX);
    assign engaged_s     = (state_r == CC_ACTIVE) || (state_r == CC_OVERRIDE);
    assign engaged_nx_s  = (state_nx_s == CC_ACTIVE) || (state_nx_s == CC_OVERRIDE);

    // Saturating target adjustments; the 9-bit forms catch overflow and underflow.
    assign tgt_sum_s  = {1'b0, target_r} + {1'b0, SPD_STEP};
    assign tgt_diff_s = {1'b0, target_r} - {1'b0, SPD_STEP};
    assign tgt_up_s   = (tgt_sum_s > {1'b0, SPD_MAX}) ? SPD_MAX : tgt_sum_s[7:0];
    assign tgt_dn_s   = (tgt_diff_s[8] || (tgt_diff_s[7:0] < SPD_MIN)) ? SPD_MIN : tgt_diff_s[7:0];

    // Next state and target for the coming tick, in falling priority order.
    always_comb begin
        state_nx_s  = state_r;
        target_nx_s = target_r;
        if (!sw_enable || !engine_on) begin
            state_nx_s  = CC_OFF;
            target_nx_s = 8'd0;
        end else if (engaged_s && (brake || cancel_edge_s || !gear_is_d)) begin
            state_nx_s = CC_STANDBY;
        end else begin
            case (state_r)
                CC_OFF: begin
                    state_nx_s = CC_STANDBY;
                end
                CC_STANDBY: begin
                    if (set_edge_s && engage_ok_s) begin
                        state_nx_s  = CC_ACTIVE;
                        target_nx_s = speed;
                    end else if (res_edge_s && engage_ok_s && (target_r != 8'd0)) begin
                        state_nx_s = CC_ACTIVE;
                    end else begin
                        state_nx_s = CC_STANDBY;
                    end
                end
                CC_ACTIVE: begin
                    if (set_edge_s && res_edge_s) begin
                        state_nx_s = CC_ACTIVE;
                    end else if (set_edge_s) begin
                        target_nx_s = tgt_up_s;
                    end else if (res_edge_s) begin
                        target_nx_s = tgt_dn_s;
                    end else if (adc_accel > cmd_r) begin
                        state_nx_s = CC_OVERRIDE;
                    end else begin
                        state_nx_s = CC_ACTIVE;
                    end
                end
                CC_OVERRIDE: begin
                    if (adc_accel <= OVR_THRESH) begin
                        state_nx_s = CC_ACTIVE;
                    end else begin
                        state_nx_s = CC_OVERRIDE;
                    end
                end
                default: begin
                    state_nx_s  = CC_OFF;
                    target_nx_s = 8'd0;
                end
            endcase
        end
    end

    // Sequencer registers: tick-paced state/target/command, per-clock output mux.
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            state_r         <= CC_OFF;
            target_r        <= 8'd0;
            cmd_r           <= 8'd0;
            accel_out_r     <= 8'd0;
            cruise_active_r <= 1'b0;
            prev_set_r      <= 1'b0;
            prev_res_r      <= 1'b0;
            prev_cancel_r   <= 1'b0;
        end else begin
            accel_out_r <= (state_r == CC_ACTIVE) ? cmd_r : adc_accel;
            if (tick_speed) begin
                prev_set_r      <= key_set;
                prev_res_r      <= key_res;
                prev_cancel_r   <= key_cancel;
                state_r         <= state_nx_s;
                target_r        <= target_nx_s;
                cruise_active_r <= engaged_nx_s;
                // Computed from the new target so the first ACTIVE cycle already has it.
                if (engaged_nx_s) begin
                    cmd_r <= calc_cmd(target_nx_s, speed);
                end
            end
        end
    end

    assign accel_out     = accel_out_r;
    assign target_speed  = target_r;
    assign cruise_active = cruise_active_r;
    assign cc_state      = state_r;

endmodule

// File: tb/tb_cruise_ctrl.sv
// Scoreboard bench for cruise_ctrl: a behavioural model predicts every clock's outputs,
// a separate monitor pops and compares them; directed scenarios then random traffic.
module tb_cruise_ctrl;

    logic       CLK = 1'b0;
    logic       global_safe_rst = 1'b1;
    logic       tick_speed = 1'b0;
    logic       engine_on = 1'b0;
    logic       sw_enable = 1'b0;
    logic       gear_is_d = 1'b0;
    logic [7:0] speed = 8'd0;
    logic [7:0] adc_accel = 8'd0;
    logic       brake = 1'b0;
    logic       key_set = 1'b0;
    logic       key_res = 1'b0;
    logic       key_cancel = 1'b0;
    logic [7:0] accel_out;
    logic [7:0] target_speed;
    logic       cruise_active;
    logic [1:0] cc_state;

    cruise_ctrl dut (
        .CLK(CLK), .global_safe_rst(global_safe_rst), .tick_speed(tick_speed),
        .engine_on(engine_on), .sw_enable(sw_enable), .gear_is_d(gear_is_d),
        .speed(speed), .adc_accel(adc_accel), .brake(brake),
        .key_set(key_set), .key_res(key_res), .key_cancel(key_cancel),
        .accel_out(accel_out), .target_speed(target_speed),
        .cruise_active(cruise_active), .cc_state(cc_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int accel;
        int target;
        int st;
        int act;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: mode 0 off, 1 standby, 2 holding, 3 driver override.
    int m_state = 0;
    int m_target = 0;
    int m_cmd = 0;
    bit m_ps = 0, m_pr = 0, m_pc = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Predict the outputs after the next rising edge from the current inputs.
    task automatic model_edge();
        exp_t e;
        bit se, re, ce, ok;
        int ns, nt, spd, a;
        spd = speed;
        a = adc_accel;
        e.accel = (m_state == 2) ? m_cmd : a;
        if (tick_speed) begin
            se = key_set && !m_ps;
            re = key_res && !m_pr;
            ce = key_cancel && !m_pc;
            m_ps = key_set; m_pr = key_res; m_pc = key_cancel;
            ok = engine_on && gear_is_d && !brake && spd >= 30 && spd <= 180;
            ns = m_state;
            nt = m_target;
            if (!sw_enable || !engine_on) begin
                ns = 0; nt = 0;
            end else if (m_state >= 2 && (brake || ce || !gear_is_d)) begin
                ns = 1;
            end else if (m_state == 0) begin
                ns = 1;
            end else if (m_state == 1) begin
                if (se && ok) begin
                    ns = 2; nt = spd;
                end else if (re && ok && nt != 0) begin
                    ns = 2;
                end
            end else if (m_state == 2) begin
                if (se && !re) nt = (nt + 5 > 180) ? 180 : nt + 5;
                else if (re && !se) nt = (nt - 5 < 30) ? 30 : nt - 5;
                else if (!se && !re && a > m_cmd) ns = 3;
            end else if (a <= 10) begin
                ns = 2;
            end
            if (ns >= 2) begin
                m_cmd = 60 + 4 * (nt - spd);
                if (m_cmd < 0) m_cmd = 0;
                if (m_cmd > 255) m_cmd = 255;
            end
            m_state = ns;
            m_target = nt;
        end
        e.target = m_target;
        e.st = m_state;
        e.act = (m_state >= 2) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic cycle(input bit t);
        tick_speed = t;
        model_edge();
        @(negedge CLK);
    endtask

    // One speed tick followed by three plain clocks.
    task automatic tk();
        cycle(1'b1);
        repeat (3) cycle(1'b0);
    endtask

    task automatic press_set();
        key_set = 1'b1; tk(); key_set = 1'b0; tk();
    endtask

    task automatic press_res();
        key_res = 1'b1; tk(); key_res = 1'b0; tk();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_accel"}, accel_out, 0);
        chk({tag, "_target"}, target_speed, 0);
        chk({tag, "_state"}, cc_state, 0);
        chk({tag, "_active"}, cruise_active, 0);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for CLK.
    task automatic mid_reset();
        #2 global_safe_rst = 1'b1;
        #1 chk_zero("async_rst");
        m_state = 0; m_target = 0; m_cmd = 0;
        m_ps = 0; m_pr = 0; m_pc = 0;
        tick_speed = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        global_safe_rst = 1'b0;
    endtask

    // Monitor: compares every post-edge output against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (!global_safe_rst && q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (accel_out != e.accel || target_speed != e.target ||
                    cc_state != e.st || cruise_active != e.act) begin
                    n_errors++;
                    $display("FAIL scoreboard at %0t: accel/target/state/active got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                             $time, accel_out, target_speed, cc_state, cruise_active,
                             e.accel, e.target, e.st, e.act);
                end
            end
        end
    end

    initial begin : stimulus
        int s;
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        global_safe_rst = 1'b0;

        engine_on = 1'b1; sw_enable = 1'b1; gear_is_d = 1'b1; speed = 8'd80; adc_accel = 8'd0;
        tk();
        press_set();
        chk("engage_state", cc_state, 2);
        chk("engage_target", target_speed, 80);
        chk("engage_accel", accel_out, 60);
        speed = 8'd75; tk();
        chk("cmd_below_target", accel_out, 80);
        speed = 8'd100; tk();
        chk("cmd_clamp_low", accel_out, 0);

        brake = 1'b1; adc_accel = 8'd7; tk(); brake = 1'b0;
        chk("brake_state", cc_state, 1);
        chk("brake_target_kept", target_speed, 80);
        chk("standby_passthru", accel_out, 7);
        speed = 8'd60; press_res();
        chk("resume_state", cc_state, 2);
        chk("resume_target", target_speed, 80);

        speed = 8'd80; tk();
        adc_accel = 8'd150; tk();
        chk("override_state", cc_state, 3);
        chk("override_accel", accel_out, 150);
        adc_accel = 8'd8; tk();
        chk("override_exit", cc_state, 2);
        chk("override_exit_accel", accel_out, 60);
        adc_accel = 8'd0;

        brake = 1'b1; tk(); brake = 1'b0;
        speed = 8'd178; press_set();
        press_set();
        chk("target_to_max", target_speed, 180);
        press_set();
        chk("target_sat_max", target_speed, 180);
        key_cancel = 1'b1; tk(); key_cancel = 1'b0; tk();
        chk("cancel_state", cc_state, 1);
        speed = 8'd32; press_set();
        press_res();
        chk("target_sat_min", target_speed, 30);

        sw_enable = 1'b0; tk();
        chk("sw_off_state", cc_state, 0);
        chk("sw_off_target", target_speed, 0);
        sw_enable = 1'b1; tk();
        speed = 8'd20; press_set();
        chk("low_speed_refused", cc_state, 1);
        speed = 8'd80; gear_is_d = 1'b0; press_set();
        chk("gear_n_refused", target_speed, 0);
        gear_is_d = 1'b1; brake = 1'b1; press_set(); brake = 1'b0;
        chk("brake_refused", cc_state, 1);

        key_set = 1'b1;
        repeat (10) tk();
        key_set = 1'b0; tk();
        chk("held_key_single", target_speed, 80);
        mid_reset();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) < 1) sw_enable = ~sw_enable;
            if ($urandom_range(99) < 1) engine_on = ~engine_on;
            if ($urandom_range(99) < 1) gear_is_d = ~gear_is_d;
            if ($urandom_range(99) < 12) key_set = ~key_set;
            if ($urandom_range(99) < 12) key_res = ~key_res;
            if ($urandom_range(99) < 3) key_cancel = ~key_cancel;
            brake = ($urandom_range(99) < 3);
            s = int'(speed) + int'($urandom_range(6)) - 3;
            if ($urandom_range(99) < 2) s = $urandom_range(195, 15);
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            speed = s[7:0];
            adc_accel = ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(255));
            cycle($urandom_range(2) == 0);
        end

        @(posedge CLK);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
